// File: rtl/r3_bfly_sched.sv
// Radix-3 butterfly input scheduler: gathers three serial complex samples per butterfly and
// presents them as a registered triplet, stepping butterfly and stage indices per transform.
module r3_bfly_sched #(
    parameter int unsigned N_BFLY  = 9,
    parameter int unsigned N_STAGE = 3,
    parameter int unsigned IDX_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             s_valid,
    input  logic [31:0]      s_re,
    input  logic [31:0]      s_img,
    output logic             s_ready,
    output logic [31:0]      a_re,
    output logic [31:0]      a_img,
    output logic [31:0]      b1_re,
    output logic [31:0]      b1_img,
    output logic [31:0]      b2_re,
    output logic [31:0]      b2_img,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [IDX_W-1:0] bfly_idx,
    output logic [IDX_W-1:0] stage_idx,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {StIdle, StCollect, StIssue, StDone} state_e;

    localparam logic [IDX_W-1:0] BflyLast  = IDX_W'(N_BFLY - 1);
    localparam logic [IDX_W-1:0] StageLast = IDX_W'(N_STAGE - 1);

    state_e             state_q, state_d;
    logic [1:0]         slot_q, slot_d;
    logic [IDX_W-1:0]   bfly_idx_q, bfly_idx_d;
    logic [IDX_W-1:0]   stage_idx_q, stage_idx_d;
    logic [31:0]        a_re_q, a_re_d, a_img_q, a_img_d;
    logic [31:0]        b1_re_q, b1_re_d, b1_img_q, b1_img_d;
    logic [31:0]        b2_re_q, b2_re_d, b2_img_q, b2_img_d;

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        bfly_idx_d  = bfly_idx_q;
        stage_idx_d = stage_idx_q;
        a_re_d      = a_re_q;
        a_img_d     = a_img_q;
        b1_re_d     = b1_re_q;
        b1_img_d    = b1_img_q;
        b2_re_d     = b2_re_q;
        b2_img_d    = b2_img_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StCollect;
                    slot_d      = 2'd0;
                    bfly_idx_d  = '0;
                    stage_idx_d = '0;
                end
            end
            StCollect: begin
                if (s_valid) begin
                    unique case (slot_q)
                        2'd0: begin
                            a_re_d  = s_re;
                            a_img_d = s_img;
                        end
                        2'd1: begin
                            b1_re_d  = s_re;
                            b1_img_d = s_img;
                        end
                        default: begin
                            b2_re_d  = s_re;
                            b2_img_d = s_img;
                        end
                    endcase
                    if (slot_q == 2'd2) begin
                        slot_d  = 2'd0;
                        state_d = StIssue;
                    end else begin
                        slot_d = slot_q + 2'd1;
                    end
                end
            end
            StIssue: begin
                if (m_ready) begin
                    if (bfly_idx_q != BflyLast) begin
                        bfly_idx_d = bfly_idx_q + 1'b1;
                        state_d    = StCollect;
                    end else if (stage_idx_q != StageLast) begin
                        bfly_idx_d  = '0;
                        stage_idx_d = stage_idx_q + 1'b1;
                        state_d     = StCollect;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                // Indices read zero from the first IDLE cycle onward.
                state_d     = StIdle;
                bfly_idx_d  = '0;
                stage_idx_d = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            slot_q      <= 2'd0;
            bfly_idx_q  <= '0;
            stage_idx_q <= '0;
            a_re_q      <= '0;
            a_img_q     <= '0;
            b1_re_q     <= '0;
            b1_img_q    <= '0;
            b2_re_q     <= '0;
            b2_img_q    <= '0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            bfly_idx_q  <= bfly_idx_d;
            stage_idx_q <= stage_idx_d;
            a_re_q      <= a_re_d;
            a_img_q     <= a_img_d;
            b1_re_q     <= b1_re_d;
            b1_img_q    <= b1_img_d;
            b2_re_q     <= b2_re_d;
            b2_img_q    <= b2_img_d;
        end
    end

    // Handshake and status flags decode straight from state so reset clears them at once.
    always_comb begin
        s_ready = (state_q == StCollect);
        m_valid = (state_q == StIssue);
        busy    = (state_q != StIdle);
        done    = (state_q == StDone);
    end

    assign a_re      = a_re_q;
    assign a_img     = a_img_q;
    assign b1_re     = b1_re_q;
    assign b1_img    = b1_img_q;
    assign b2_re     = b2_re_q;
    assign b2_img    = b2_img_q;
    assign bfly_idx  = bfly_idx_q;
    assign stage_idx = stage_idx_q;

endmodule

// File: tb/tb_r3_bfly_sched.sv
// Self-checking bench for r3_bfly_sched: randomized traffic against a sample-count based model
// plus directed scenarios for backpressure, ignored inputs and mid-run reset.
module tb_r3_bfly_sched;

    localparam int NB    = 9;
    localparam int NS    = 3;
    localparam int TOTAL = NB * NS;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, s_valid, s_ready, m_valid, m_ready, busy, done;
    logic [31:0] s_re, s_img, a_re, a_img, b1_re, b1_img, b2_re, b2_img;
    logic [3:0]  bfly_idx, stage_idx;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: a transform is a run of accepted samples; issue k is due once 3*(k+1) are in.
    bit          m_run, m_done;
    int          m_acc, m_iss;
    logic [31:0] q_re[$], q_im[$];

    r3_bfly_sched #(.N_BFLY(NB), .N_STAGE(NS), .IDX_W(4)) dut (
        .clk(clk), .rst(rst), .start(start),
        .s_valid(s_valid), .s_re(s_re), .s_img(s_img), .s_ready(s_ready),
        .a_re(a_re), .a_img(a_img), .b1_re(b1_re), .b1_img(b1_img),
        .b2_re(b2_re), .b2_img(b2_img),
        .m_valid(m_valid), .m_ready(m_ready),
        .bfly_idx(bfly_idx), .stage_idx(stage_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic bit m_issue();
        return m_run && (m_acc == 3 * (m_iss + 1));
    endfunction

    task automatic model_clear();
        m_run = 0; m_done = 0; m_acc = 0; m_iss = 0;
        q_re.delete(); q_im.delete();
    endtask

    // Drive one cycle of inputs and predict their effect at the coming rising edge.
    task automatic advance(input logic sv, input logic [31:0] re, input logic [31:0] im,
                           input logic mr, input logic st);
        s_valid = sv; s_re = re; s_img = im; m_ready = mr; start = st;
        if (m_done) begin
            m_done = 0;
        end else if (!m_run) begin
            if (st) begin
                model_clear();
                m_run = 1;
            end
        end else if (m_issue()) begin
            if (mr) begin
                m_iss++;
                if (m_iss == TOTAL) begin
                    m_run = 0;
                    m_done = 1;
                end
            end
        end else if (sv) begin
            q_re.push_back(re);
            q_im.push_back(im);
            m_acc++;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        s_valid = 0; s_re = '0; s_img = '0; m_ready = 0; start = 0;
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_valid = 0; s_re = '0; s_img = '0; m_ready = 0; start = 0;
        model_clear();
        #1;
        n_checks++;
        if ({s_ready, m_valid, busy, done} !== 4'b0000) begin
            $display("FAIL reset_flags: got %b want 0000", {s_ready, m_valid, busy, done});
        end else n_pass++;
        n_checks++;
        if ({a_re, a_img, b1_re, b1_img, b2_re, b2_img, bfly_idx, stage_idx} !== '0) begin
            $display("FAIL reset_data: got %h want 0",
                     {a_re, a_img, b1_re, b1_img, b2_re, b2_img, bfly_idx, stage_idx});
        end else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        apply_reset();
        @(negedge clk); advance(0, 0, 0, 1, 1);
        @(negedge clk);
        n_checks++;
        if (s_ready !== 1'b1 || busy !== 1'b1) begin
            $display("FAIL basic_collect: got ready=%b busy=%b want 1 1", s_ready, busy);
        end else n_pass++;
        advance(1, 3, 0, 1, 0);
        @(negedge clk); advance(1, 5, 1, 1, 0);
        @(negedge clk); advance(1, 7, 2, 1, 0);
        @(negedge clk);
        n_checks++;
        if (m_valid !== 1'b1 || s_ready !== 1'b0) begin
            $display("FAIL basic_latency: got m_valid=%b s_ready=%b want 1 0", m_valid, s_ready);
        end else n_pass++;
        n_checks++;
        if ({a_re, a_img, b1_re, b1_img, b2_re, b2_img, bfly_idx, stage_idx} !==
            {32'd3, 32'd0, 32'd5, 32'd1, 32'd7, 32'd2, 4'd0, 4'd0}) begin
            $display("FAIL basic_triplet: got %h want 3/0 5/1 7/2 idx 0/0",
                     {a_re, a_img, b1_re, b1_img, b2_re, b2_img, bfly_idx, stage_idx});
        end else n_pass++;
    endtask

    // One full transform with probabilistic valid/ready (percent); start is sprinkled randomly.
    task automatic run_transform(input string name, input int pv, input int pr);
        int issues = 0, dones = 0, cyc = 0, k;
        logic sv, mr;
        logic [3:0] eb, es;
        apply_reset();
        @(negedge clk); advance(0, 0, 0, 0, 1);
        while ((m_run || m_done) && cyc < 2000) begin
            @(negedge clk); cyc++;
            n_checks++;
            if ({s_ready, m_valid, busy, done} !==
                {m_run && !m_issue(), m_issue(), m_run || m_done, m_done}) begin
                $display("FAIL %s_flags: cycle %0d got %b want %b", name, cyc,
                         {s_ready, m_valid, busy, done},
                         {m_run && !m_issue(), m_issue(), m_run || m_done, m_done});
            end else n_pass++;
            if (m_issue()) begin
                k  = 3 * m_iss;
                eb = 4'(m_iss % NB);
                es = 4'(m_iss / NB);
                n_checks++;
                if ({a_re, a_img, b1_re, b1_img, b2_re, b2_img, bfly_idx, stage_idx} !==
                    {q_re[k], q_im[k], q_re[k+1], q_im[k+1], q_re[k+2], q_im[k+2], eb, es}) begin
                    $display("FAIL %s_issue%0d: got %h want %h", name, m_iss,
                             {a_re, a_img, b1_re, b1_img, b2_re, b2_img, bfly_idx, stage_idx},
                             {q_re[k], q_im[k], q_re[k+1], q_im[k+1], q_re[k+2], q_im[k+2],
                              eb, es});
                end else n_pass++;
            end
            if (done) dones++;
            sv = ($urandom_range(99) < pv);
            mr = ($urandom_range(99) < pr);
            if (m_valid && mr) issues++;
            advance(sv, $urandom, $urandom, mr, $urandom_range(7) == 0);
        end
        @(negedge clk);
        n_checks++;
        if (issues != TOTAL || dones != 1 || cyc >= 2000) begin
            $display("FAIL %s_count: got issues=%0d dones=%0d cycles=%0d want %0d 1 <2000",
                     name, issues, dones, cyc, TOTAL);
        end else n_pass++;
        n_checks++;
        if ({busy, done, s_ready, m_valid, bfly_idx, stage_idx} !== '0) begin
            $display("FAIL %s_idle: got %h want 0", name,
                     {busy, done, s_ready, m_valid, bfly_idx, stage_idx});
        end else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [31:0] r[3], i[3];
        apply_reset();
        @(negedge clk); advance(0, 0, 0, 0, 1);
        for (int j = 0; j < 3; j++) begin
            r[j] = $urandom; i[j] = $urandom;
            @(negedge clk); advance(1, r[j], i[j], 0, 0);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_checks++;
            if ({m_valid, s_ready, a_re, a_img, b1_re, b1_img, b2_re, b2_img, bfly_idx,
                 stage_idx} !== {2'b10, r[0], i[0], r[1], i[1], r[2], i[2], 8'h00}) begin
                $display("FAIL stall_c%0d: got %h want %h", c,
                         {m_valid, s_ready, a_re, a_img, b1_re, b1_img, b2_re, b2_img},
                         {2'b10, r[0], i[0], r[1], i[1], r[2], i[2]});
            end else n_pass++;
            if (c < 5) advance(1, $urandom, $urandom, 0, 0);
            else advance(0, 0, 0, 1, 0);
        end
        for (int j = 0; j < 3; j++) begin
            r[j] = $urandom; i[j] = $urandom;
            @(negedge clk); advance(1, r[j], i[j], 0, 0);
        end
        @(negedge clk);
        n_checks++;
        if ({m_valid, a_re, a_img, b1_re, b1_img, b2_re, b2_img, bfly_idx, stage_idx} !==
            {1'b1, r[0], i[0], r[1], i[1], r[2], i[2], 4'd1, 4'd0}) begin
            $display("FAIL stall_next: got %h want %h",
                     {m_valid, a_re, a_img, b1_re, b1_img, b2_re, b2_img, bfly_idx, stage_idx},
                     {1'b1, r[0], i[0], r[1], i[1], r[2], i[2], 4'd1, 4'd0});
        end else n_pass++;
    endtask

    task automatic test_ignored();
        apply_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); advance(1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1, 0);
        end
        @(negedge clk);
        n_checks++;
        if ({s_ready, busy, m_valid, a_re, a_img} !== '0) begin
            $display("FAIL idle_capture: got %h want 0", {s_ready, busy, m_valid, a_re, a_img});
        end else n_pass++;
        advance(0, 0, 0, 0, 1);
        @(negedge clk); advance(1, 32'h11, 32'h21, 0, 0);
        @(negedge clk); advance(1, 32'h12, 32'h22, 0, 1);
        @(negedge clk); advance(1, 32'h13, 32'h23, 0, 1);
        @(negedge clk);
        n_checks++;
        if ({m_valid, a_re, a_img, b1_re, b1_img, b2_re, b2_img, bfly_idx} !==
            {1'b1, 32'h11, 32'h21, 32'h12, 32'h22, 32'h13, 32'h23, 4'd0}) begin
            $display("FAIL start_in_collect: got %h want 11/21 12/22 13/23 idx 0",
                     {m_valid, a_re, a_img, b1_re, b1_img, b2_re, b2_img, bfly_idx});
        end else n_pass++;
        advance(0, 0, 0, 1, 1);
        @(negedge clk);
        n_checks++;
        if ({s_ready, bfly_idx} !== {1'b1, 4'd1}) begin
            $display("FAIL start_in_issue: got ready=%b bfly=%0d want 1 1", s_ready, bfly_idx);
        end else n_pass++;
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        apply_reset();
        @(negedge clk); advance(0, 0, 0, 0, 1);
        while (!(m_iss == 4 && m_acc == 14) && guard < 200) begin
            @(negedge clk); guard++;
            advance(1, $urandom, $urandom, 1, 0);
        end
        @(negedge clk);
        n_checks++;
        if (guard >= 200 || busy !== 1'b1 || bfly_idx !== 4'd4) begin
            $display("FAIL midrst_reach: got guard=%0d busy=%b bfly=%0d want <200 1 4",
                     guard, busy, bfly_idx);
        end else n_pass++;
        #2 rst = 1'b1;
        model_clear();
        #1;
        n_checks++;
        if ({s_ready, m_valid, busy, done, a_re, a_img, b1_re, b1_img, b2_re, b2_img,
             bfly_idx, stage_idx} !== '0) begin
            $display("FAIL midrst_clear: got %h want 0",
                     {s_ready, m_valid, busy, done, a_re, a_img, b1_re, b1_img, b2_re, b2_img,
                      bfly_idx, stage_idx});
        end else n_pass++;
        @(negedge clk); rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            advance(1, $urandom, $urandom, 1, 0);
            @(negedge clk);
        end
        n_checks++;
        if ({busy, s_ready, a_re} !== '0) begin
            $display("FAIL midrst_wait: got %h want 0", {busy, s_ready, a_re});
        end else n_pass++;
        advance(0, 0, 0, 0, 1);
        @(negedge clk); advance(1, 32'hA0, 32'hB0, 0, 0);
        @(negedge clk); advance(1, 32'hA1, 32'hB1, 0, 0);
        @(negedge clk); advance(1, 32'hA2, 32'hB2, 0, 0);
        @(negedge clk);
        n_checks++;
        if ({m_valid, a_re, a_img, b1_re, b1_img, b2_re, b2_img, bfly_idx, stage_idx} !==
            {1'b1, 32'hA0, 32'hB0, 32'hA1, 32'hB1, 32'hA2, 32'hB2, 4'd0, 4'd0}) begin
            $display("FAIL midrst_first: got %h want A0/B0 A1/B1 A2/B2 idx 0/0",
                     {m_valid, a_re, a_img, b1_re, b1_img, b2_re, b2_img, bfly_idx, stage_idx});
        end else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        run_transform("full", 100, 100);
        run_transform("rand", 60, 50);
        test_backpressure();
        test_ignored();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/r3_bfly_sched.md
R3_BFLY_SCHED -- requirements
Module: r3_bfly_sched

Interface
REQ-001 SHALL have parameter N_BFLY, default 9, butterflies per stage (>=1).
REQ-002 SHALL have parameter N_STAGE, default 3, stages per transform (>=1).
REQ-003 SHALL have parameter IDX_W, default 4, width of the bfly_idx and stage_idx outputs; 2^IDX_W >= max(N_BFLY, N_STAGE).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a transform.
REQ-007 SHALL have ports s_valid input 1, s_re input 32, s_img input 32  serial complex sample stream.
REQ-008 SHALL have port s_ready  output  1  sample accepted when s_valid and s_ready are both high.
REQ-009 SHALL have ports a_re, a_img, b1_re, b1_img, b2_re, b2_img  output  32 each  registered butterfly input triplet.
REQ-010 SHALL have ports m_valid output 1 and m_ready input 1  triplet handshake to the butterfly pipeline.
REQ-011 SHALL have ports bfly_idx output IDX_W and stage_idx output IDX_W  index of the triplet presented, used for twiddle selection.
REQ-012 SHALL have ports busy output 1 and done output 1  busy is high when state != IDLE; done is a one-cycle completion pulse.

Function
REQ-013 SHALL implement FSM states IDLE, COLLECT, ISSUE and DONE.
REQ-014 In IDLE, the block SHALL hold s_ready=0 and m_valid=0; start=1 SHALL move the FSM to COLLECT and clear slot, bfly_idx and stage_idx.
REQ-015 start SHALL be ignored in every state except IDLE.
REQ-016 In COLLECT, s_ready SHALL be 1; each accept SHALL store (s_re,s_img) into slot 0->a, 1->b1, 2->b2 and increment a 2-bit slot counter.
REQ-017 The third accept SHALL move the FSM to ISSUE and reset slot to 0; m_valid SHALL be high in the next cycle (latency 1 cycle from the third accept).
REQ-018 In ISSUE, m_valid SHALL be 1 and s_ready SHALL be 0; the triplet, bfly_idx and stage_idx SHALL stay stable until m_ready=1.
REQ-019 On an ISSUE handshake with bfly_idx<N_BFLY-1, the block SHALL increment bfly_idx and return to COLLECT.
REQ-020 On an ISSUE handshake with bfly_idx=N_BFLY-1 and stage_idx<N_STAGE-1, the block SHALL wrap bfly_idx to 0, increment stage_idx and return to COLLECT.
REQ-021 On an ISSUE handshake with bfly_idx=N_BFLY-1 and stage_idx=N_STAGE-1, the block SHALL go to DONE.
REQ-022 DONE SHALL last exactly one cycle with done=1 and then go to IDLE; the index outputs SHALL return to 0 on entry to IDLE.
REQ-023 Each butterfly SHALL take at least 4 cycles (3 accepts plus 1 issue); the block has no overlap between issue and collect.
REQ-024 s_valid while s_ready=0 SHALL have no effect; no sample SHALL be stored.
REQ-025 m_ready while m_valid=0 SHALL have no effect.
REQ-026 Sample data SHALL pass through bit-exact, with no arithmetic applied.
REQ-027 Triplet registers SHALL hold their last values after DONE until overwritten.

Reset
REQ-028 Asserting rst SHALL immediately force state to IDLE, clear slot, bfly_idx and stage_idx, and drive s_ready, m_valid, busy, done and all triplet outputs to 0.
REQ-029 A reset during COLLECT or ISSUE SHALL discard any partial triplet; after release, the block SHALL wait for a new start.

Verification
REQ-030 Basic: reset, start, feed 3+0j, 5+1j, 7+2j with m_ready=1 -> m_valid one cycle after the 3rd accept with a=3/0, b1=5/1, b2=7/2, bfly_idx=0, stage_idx=0.
REQ-031 Full run: N_BFLY=9, N_STAGE=3, continuous valid/ready -> exactly 27 issues, stage_idx steps 0->1->2 after issues 9 and 18, done pulses once after issue 27, then busy=0.
REQ-032 Backpressure: hold m_ready=0 for 5 cycles in ISSUE -> triplet and indices unchanged, s_ready=0 throughout, no sample lost.
REQ-033 Ignored inputs: s_valid=1 in IDLE, and start pulsed in COLLECT -> no capture and no counter restart.
REQ-034 Reset mid-run: assert rst after 2 accepts of butterfly 4 -> all outputs 0; after a new start, the first issue has bfly_idx=0 and contains only new samples.
